mem_read_stream_master: RTL and testbench
=========================================

Name: mem_read_stream_master

Overview:
Parametrised Avalon-MM read master. It fetches a block of consecutive words, given by start address and length, using pipelined reads with readdatavalid. Returned words are buffered in an internal FIFO and presented on a valid/ready stream. It replaces the single-beat pass-through read port in the memory-access path between pixel-processing logic and on-chip/SDRAM memory.

Parameters:
DATAWIDTH, 32, word width in bits (multiple of 8)
BYTEENABLEWIDTH, 4, DATAWIDTH/8; byte address stride per word
ADDRESSWIDTH, 20, Avalon byte-address width
LENWIDTH, 16, width of the word-count field
FIFODEPTH, 32, buffer depth in words (power of 2, ≥4)
FIFODEPTH_LOG2, 5, log2(FIFODEPTH)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset)
go  in  1  one-cycle start pulse; sampled only in IDLE
start_addr  in  ADDRESSWIDTH  byte address of first word (must be BYTEENABLEWIDTH-aligned)
length  in  LENWIDTH  number of words to read
busy  out  1  high from accepted go until the last word leaves the stream port
done  out  1  one-cycle pulse when the transfer completes
oData  out  DATAWIDTH  stream data
oValid  out  1  oData is valid
iReady  in  1  consumer accepts oData when oValid&iReady
master_address  out  ADDRESSWIDTH  Avalon address
master_read  out  1  Avalon read request
master_byteenable  out  BYTEENABLEWIDTH  always all ones
master_readdata  in  DATAWIDTH  Avalon read data
master_readdatavalid  in  1  read data return strobe
master_waitrequest  in  1  slave stall

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, busy=0, done=0, master_read=0, master_address=0, oValid=0. FIFO and counters are cleared. A reset mid-transfer abandons it; any readdatavalid arriving afterwards is discarded until the next go.
- States are IDLE, ISSUE, DRAIN.
- IDLE:
  - On go with length≠0: latch addr←start_addr and remaining_issue←length. Go to ISSUE. busy=1 from the next cycle.
  - On go with length==0: pulse done the next cycle. busy stays 0.
  - go outside IDLE is ignored.
- ISSUE:
  - master_read=1 whenever remaining_issue≠0 and (fifo_used + pending) < FIFODEPTH. This guarantees FIFO space for every outstanding read.
  - pending counts issued reads whose data has not yet returned.
  - A read is accepted on a cycle with master_read=1 and master_waitrequest=0. On accept: addr += BYTEENABLEWIDTH (wraps modulo 2^ADDRESSWIDTH), remaining_issue−−, pending++.
  - While waitrequest=1, address and read stay stable.
  - When remaining_issue reaches 0, go to DRAIN.
- master_readdatavalid: write master_readdata into the FIFO and decrement pending. Accept and readdatavalid in the same cycle leave pending unchanged.
- DRAIN: wait until pending==0 and the FIFO is empty, counting the final oValid&iReady pop. Then go to IDLE. done=1 for exactly that one cycle; busy falls on the same edge.
- Stream output is show-ahead: oValid=!fifo_empty and oData=FIFO head.
  - Pop on oValid&iReady.
  - Simultaneous push and pop keep the count unchanged.
  - A push into an empty FIFO becomes visible on oValid one cycle later.
- Latency: first word reaches oValid no earlier than slave read latency + 1 cycle after accept. Throughput is one word per cycle when the slave and consumer never stall.
- Width rules:
  - fifo_used + pending is compared in FIFODEPTH_LOG2+1 bits.
  - remaining_issue is LENWIDTH bits.
  - The credit rule makes FIFO overflow impossible. The verifier asserts no push on a full FIFO and no pop on an empty one.

Decomposition:
- Package mem_read_pkg holds:
  - state encoding (IDLE/ISSUE/DRAIN)
  - default width constants
  - a function deriving BYTEENABLEWIDTH from DATAWIDTH
- Sub-module mem_read_fifo: synchronous show-ahead FIFO parametrised by DATAWIDTH/FIFODEPTH/FIFODEPTH_LOG2.
  - Outputs: used count, empty, full.
  - Reset: same synchronous active-low reset.

Test Plan:
- Basic burst: go, start_addr=0x100, length=8, zero-latency slave (1-cycle readdatavalid), iReady=1 → addresses 0x100..0x11C stepped by 4, 8 words out in order, done one cycle after the last pop, busy low afterwards.
- Backpressure: length=64, FIFODEPTH=32, iReady=0 for 100 cycles → master_read stops once fifo_used+pending=32. After iReady=1, all 64 words delivered with no loss or overflow.
- Waitrequest: slave holds waitrequest high for 3 cycles on every 4th read, length=16 → master_address/master_read stable while stalled, exactly 16 accepts, data in order.
- Zero length and go while busy: go with length=0 → done pulse next cycle, no master_read. A second go during a length=10 transfer → ignored, only 10 reads issued.
- Address wrap: start_addr=0xFFFF8, length=4 → addresses 0xFFFF8, 0xFFFFC, 0x00000, 0x00004.
- Reset mid-operation: reset=0 for one cycle after 5 of 20 reads are accepted → master_read=0, oValid=0, busy=0 next cycle. Late readdatavalid is not emitted. A new go of length=4 then completes correctly.

Source files
------------

// File: rtl/mem_read_pkg.sv
// Shared types and defaults for the streaming Avalon-MM read master.
package mem_read_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_DATAWIDTH      = 32;
    localparam int DEF_ADDRESSWIDTH   = 20;
    localparam int DEF_LENWIDTH       = 16;
    localparam int DEF_FIFODEPTH      = 32;
    localparam int DEF_FIFODEPTH_LOG2 = 5;

    // Bytes per word, which is also the byte-address stride between reads.
    function automatic int be_width(input int datawidth);
        return datawidth / 8;
    endfunction

endpackage

// File: rtl/mem_read_fifo.sv
// Show-ahead FIFO: head word is on rdata whenever empty is low.
// A push becomes visible one cycle later; writes when full and reads when empty are dropped.
module mem_read_fifo #(
    parameter int DATAWIDTH      = 32,
    parameter int FIFODEPTH      = 32,
    parameter int FIFODEPTH_LOG2 = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [DATAWIDTH-1:0]      wdata,
    input  logic                      pop,
    output logic [DATAWIDTH-1:0]      rdata,
    output logic [FIFODEPTH_LOG2:0]   used,
    output logic                      empty,
    output logic                      full
);

    localparam int AW = FIFODEPTH_LOG2;
    localparam int CW = FIFODEPTH_LOG2 + 1;

    logic [DATAWIDTH-1:0] mem [FIFODEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFODEPTH));
    assign used    = count;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_read_stream_master.sv
// Block read master: pipelined Avalon-MM reads of consecutive words, buffered onto a valid/ready stream.
// Latency is slave latency + 1 from accept to oValid; reads are throttled so FIFO space exists for every outstanding read.
module mem_read_stream_master
    import mem_read_pkg::*;
#(
    parameter int DATAWIDTH       = DEF_DATAWIDTH,
    parameter int BYTEENABLEWIDTH = be_width(DATAWIDTH),
    parameter int ADDRESSWIDTH    = DEF_ADDRESSWIDTH,
    parameter int LENWIDTH        = DEF_LENWIDTH,
    parameter int FIFODEPTH       = DEF_FIFODEPTH,
    parameter int FIFODEPTH_LOG2  = DEF_FIFODEPTH_LOG2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       go,
    input  logic [ADDRESSWIDTH-1:0]    start_addr,
    input  logic [LENWIDTH-1:0]        length,
    output logic                       busy,
    output logic                       done,
    output logic [DATAWIDTH-1:0]       oData,
    output logic                       oValid,
    input  logic                       iReady,
    output logic [ADDRESSWIDTH-1:0]    master_address,
    output logic                       master_read,
    output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
    input  logic [DATAWIDTH-1:0]       master_readdata,
    input  logic                       master_readdatavalid,
    input  logic                       master_waitrequest
);

    localparam int CW = FIFODEPTH_LOG2 + 1;

    state_t                  state;
    state_t                  state_next;
    logic [ADDRESSWIDTH-1:0] addr;
    logic [LENWIDTH-1:0]     remaining;
    logic [CW-1:0]           pending;
    logic [CW-1:0]           fifo_used;
    logic [CW-1:0]           credit_sum;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    start;
    logic                    zero_go;
    logic                    accept;
    logic                    push;
    logic                    pop;
    logic                    finish;

    assign start      = (state == IDLE) && go && (length != '0);
    assign zero_go    = (state == IDLE) && go && (length == '0);
    assign accept     = master_read && !master_waitrequest;
    // Returns arriving in IDLE belong to an abandoned transfer and are dropped.
    assign push       = master_readdatavalid && (state != IDLE) && (pending != '0);
    assign pop        = oValid && iReady;
    assign credit_sum = fifo_used + pending;

    assign oValid            = !fifo_empty;
    assign busy              = (state != IDLE);
    assign master_address    = addr;
    assign master_byteenable = '1;

    always_comb begin
        state_next  = state;
        master_read = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                master_read = (remaining != '0) && (credit_sum < CW'(FIFODEPTH)) && !fifo_full;
                if (master_read && !master_waitrequest && remaining == LENWIDTH'(1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Finish on the cycle the last word is popped, not one cycle after.
                if (pending == '0 && (fifo_empty || (fifo_used == CW'(1) && pop))) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            pending   <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_next;
            done  <= finish || zero_go;
            if (start) begin
                addr      <= start_addr;
                remaining <= length;
            end else if (accept) begin
                addr      <= addr + ADDRESSWIDTH'(BYTEENABLEWIDTH);
                remaining <= remaining - LENWIDTH'(1);
            end
            case ({accept, push})
                2'b10:   pending <= pending + CW'(1);
                2'b01:   pending <= pending - CW'(1);
                default: pending <= pending;
            endcase
        end
    end

    mem_read_fifo #(
        .DATAWIDTH      (DATAWIDTH),
        .FIFODEPTH      (FIFODEPTH),
        .FIFODEPTH_LOG2 (FIFODEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (master_readdata),
        .pop   (pop),
        .rdata (oData),
        .used  (fifo_used),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_mem_read_stream_master.sv
// Bench for mem_read_stream_master: 1-cycle-latency slave model plus a data scoreboard.
module tb_mem_read_stream_master;

    logic        clk;
    logic        reset;
    logic        go;
    logic [19:0] start_addr;
    logic [15:0] length;
    logic        busy;
    logic        done;
    logic [31:0] oData;
    logic        oValid;
    logic        iReady;
    logic [19:0] master_address;
    logic        master_read;
    logic [3:0]  master_byteenable;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_waitrequest;

    mem_read_stream_master dut (
        .clk                  (clk),
        .reset                (reset),
        .go                   (go),
        .start_addr           (start_addr),
        .length               (length),
        .busy                 (busy),
        .done                 (done),
        .oData                (oData),
        .oValid               (oValid),
        .iReady               (iReady),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_byteenable    (master_byteenable),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_waitrequest   (master_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int accepts = 0;
    int pops = 0;
    int done_count = 0;
    int last_done_cycle = -1;
    int last_pop_cycle = -1;
    int stall_cycles = 0;
    int read_cycles = 0;
    int tb_used = 0;
    int tb_pending = 0;
    int stall_left = 0;
    bit go_req = 0;
    bit rst_req = 0;
    bit rst_hold = 1;
    bit pend_valid = 0;
    bit wait_mode = 0;
    bit stalled_cur = 0;
    bit held = 0;
    bit ready_val = 1;
    logic [31:0] pend_data;
    logic [19:0] exp_next_addr;
    logic [19:0] held_addr;
    logic [31:0] sb[$];

    function automatic logic [31:0] word_of(input logic [19:0] a);
        return {12'hD47, a};
    endfunction

    // One clock cycle: drive at posedge+1, sample and score at negedge.
    task automatic step();
        logic [31:0] exp_word;
        @(posedge clk);
        #1;
        cycle++;
        reset = (rst_req || rst_hold) ? 1'b0 : 1'b1;
        rst_req = 0;
        go = go_req;
        go_req = 0;
        master_readdatavalid = pend_valid;
        master_readdata = pend_valid ? pend_data : 32'hDEAD_BEEF;
        pend_valid = 0;
        if (wait_mode && stall_left > 0) begin
            master_waitrequest = 1'b1;
            stall_left--;
        end else if (wait_mode && (accepts % 4 == 3) && !stalled_cur) begin
            master_waitrequest = 1'b1;
            stall_left = 2;
            stalled_cur = 1;
        end else begin
            master_waitrequest = 1'b0;
        end
        iReady = ready_val;
        @(negedge clk);
        if (reset) begin
            if (held) begin
                checks++;
                if (master_read !== 1'b1 || master_address !== held_addr) begin
                    errors++;
                    $display("FAIL stall_stable: read=%b addr=%h, required read=1 addr=%h", master_read, master_address, held_addr);
                end
            end
            held = (master_read === 1'b1) && master_waitrequest;
            held_addr = master_address;
            if (master_read === 1'b1) begin
                read_cycles++;
                checks++;
                if (tb_used + tb_pending >= 32) begin
                    errors++;
                    $display("FAIL credit: read asserted with used+pending=%0d, required <32", tb_used + tb_pending);
                end
            end
            if (master_read === 1'b1 && master_waitrequest) stall_cycles++;
            if (master_readdatavalid && tb_pending > 0) begin
                tb_pending--;
                tb_used++;
            end
            if (master_read === 1'b1 && !master_waitrequest) begin
                checks++;
                if (master_address !== exp_next_addr) begin
                    errors++;
                    $display("FAIL read_addr: got %h, required %h", master_address, exp_next_addr);
                end
                sb.push_back(word_of(exp_next_addr));
                pend_valid = 1;
                pend_data = word_of(master_address);
                exp_next_addr = exp_next_addr + 20'd4;
                accepts++;
                tb_pending++;
                stalled_cur = 0;
            end
            if (oValid === 1'b1 && iReady) begin
                pops++;
                last_pop_cycle = cycle;
                tb_used--;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL stream_data: got unexpected word %h, required no output", oData);
                end else begin
                    exp_word = sb.pop_front();
                    if (oData !== exp_word) begin
                        errors++;
                        $display("FAIL stream_data: got %h, required %h", oData, exp_word);
                    end
                end
            end
            if (done === 1'b1) begin
                done_count++;
                last_done_cycle = cycle;
            end
        end else begin
            // The slave does not see the master's reset and may still answer.
            if (master_read === 1'b1 && !master_waitrequest) begin
                pend_valid = 1;
                pend_data = word_of(master_address);
            end
            sb.delete();
            tb_used = 0;
            tb_pending = 0;
            held = 0;
        end
    endtask

    task automatic start_go(input logic [19:0] a, input logic [15:0] n);
        start_addr = a;
        length = n;
        go_req = 1;
        exp_next_addr = a;
        accepts = 0;
        pops = 0;
        stall_cycles = 0;
        read_cycles = 0;
        stalled_cur = 0;
        stall_left = 0;
        step();
    endtask

    task automatic wait_done(input int max, input string name);
        int start;
        int i;
        start = done_count;
        i = 0;
        while (done_count == start && i < max) begin
            step();
            i++;
        end
        checks++;
        if (done_count == start) begin
            errors++;
            $display("FAIL %s_timeout: done_count=%0d after %0d cycles, required %0d", name, done_count, max, start + 1);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst_hold = 1;
        step();
        step();
        step();
        check_int("reset_busy", busy, 0);
        check_int("reset_done", done, 0);
        check_int("reset_read", master_read, 0);
        check_int("reset_valid", oValid, 0);
        check_int("reset_addr", master_address, 0);
        check_int("byteenable", master_byteenable, 4'hF);
        rst_hold = 0;
        step();
        check_int("post_reset_busy", busy, 0);
    endtask

    task automatic test_basic_burst();
        ready_val = 1;
        start_go(20'h100, 16'd8);
        check_int("basic_busy_go_cycle", busy, 0);
        step();
        check_int("basic_busy", busy, 1);
        wait_done(100, "basic");
        check_int("basic_accepts", accepts, 8);
        check_int("basic_pops", pops, 8);
        check_int("basic_done_after_pop", last_done_cycle, last_pop_cycle + 1);
        check_int("basic_busy_low", busy, 0);
        check_int("basic_sb_empty", sb.size(), 0);
        step();
        check_int("basic_done_pulse", done, 0);
    endtask

    task automatic test_backpressure();
        ready_val = 0;
        start_go(20'h1000, 16'd64);
        for (int i = 0; i < 100; i++) step();
        check_int("bp_accepts_capped", accepts, 32);
        check_int("bp_read_stopped", master_read, 0);
        check_int("bp_valid", oValid, 1);
        ready_val = 1;
        wait_done(400, "bp");
        check_int("bp_accepts", accepts, 64);
        check_int("bp_pops", pops, 64);
        check_int("bp_sb_empty", sb.size(), 0);
    endtask

    task automatic test_waitrequest();
        ready_val = 1;
        wait_mode = 1;
        start_go(20'h2000, 16'd16);
        wait_done(200, "wait");
        wait_mode = 0;
        check_int("wait_accepts", accepts, 16);
        check_int("wait_stall_cycles", stall_cycles, 12);
        check_int("wait_pops", pops, 16);
    endtask

    task automatic test_zero_length_and_busy_go();
        int d0;
        d0 = done_count;
        start_go(20'h300, 16'd0);
        step();
        check_int("zero_done", done, 1);
        check_int("zero_busy", busy, 0);
        step();
        check_int("zero_done_once", done_count - d0, 1);
        check_int("zero_reads", read_cycles, 0);
        start_go(20'h400, 16'd10);
        for (int i = 0; i < 4; i++) step();
        start_addr = 20'h800;
        length = 16'd7;
        go_req = 1;
        wait_done(100, "busy_go");
        check_int("busy_go_accepts", accepts, 10);
        check_int("busy_go_pops", pops, 10);
        for (int i = 0; i < 3; i++) step();
        check_int("busy_go_idle", busy, 0);
    endtask

    task automatic test_address_wrap();
        start_go(20'hFFFF8, 16'd4);
        wait_done(50, "wrap");
        check_int("wrap_accepts", accepts, 4);
        check_int("wrap_pops", pops, 4);
        check_int("wrap_final_addr", master_address, 20'h00008);
    endtask

    task automatic test_reset_mid_op();
        int n;
        start_go(20'h200, 16'd20);
        n = 0;
        while (accepts < 5 && n < 50) begin
            step();
            n++;
        end
        check_int("mid_reached_5", accepts >= 5, 1);
        rst_req = 1;
        step();
        pend_valid = 1;
        pend_data = 32'hBAD0_BAD0;
        step();
        check_int("mid_read_low", master_read, 0);
        check_int("mid_valid_low", oValid, 0);
        check_int("mid_busy_low", busy, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_int("mid_late_dropped", oValid, 0);
        end
        start_go(20'h40, 16'd4);
        wait_done(50, "mid_restart");
        check_int("mid_restart_accepts", accepts, 4);
        check_int("mid_restart_pops", pops, 4);
    endtask

    initial begin
        reset = 1'b0;
        go = 1'b0;
        start_addr = '0;
        length = '0;
        iReady = 1'b0;
        master_readdata = '0;
        master_readdatavalid = 1'b0;
        master_waitrequest = 1'b0;
        test_reset();
        test_basic_burst();
        test_backpressure();
        test_waitrequest();
        test_zero_length_and_busy_go();
        test_address_wrap();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
